// File: rtl/div_seq_pkg.sv
// Shared definitions for the div_seq divider sequencer: state encodings, widths and flag literals.
// DIV_SIGNED_EN (optional) enables signed DIV support in div_seq.
package div_seq_pkg;

    localparam int unsigned REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    function automatic logic [REG_BUS-1:0] neg_word(input logic [REG_BUS-1:0] v);
        return ~v + {{(REG_BUS-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only when it does not borrow.
module div_step
    import div_seq_pkg::*;
(
    input  logic [REG_BUS:0]   partial,
    input  logic [REG_BUS-1:0] divisor,
    output logic [REG_BUS-1:0] rem_next,
    output logic               q_bit
);

    logic [REG_BUS:0] diff;

    // partial < 2*divisor always holds, so a non-borrowing difference fits in REG_BUS bits.
    always_comb begin
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[REG_BUS];
        rem_next = q_bit ? diff[REG_BUS-1:0] : partial[REG_BUS-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-step restoring divider for DIV/DIVU returning {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every operation is unsigned.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t         state;
    logic [5:0]         cnt;
    logic [REG_BUS-1:0] rem;
    logic [REG_BUS-1:0] dvd;
    logic [REG_BUS-1:0] divisor_r;

    logic [REG_BUS-1:0] mag_a;
    logic [REG_BUS-1:0] mag_b;
    logic [REG_BUS-1:0] quo_fix;
    logic [REG_BUS-1:0] rem_fix;

    logic [REG_BUS-1:0] step_rem;
    logic               step_q;

    div_step u_step (
        .partial  ({rem, dvd[REG_BUS-1]}),
        .divisor  (divisor_r),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic neg_a;
    logic neg_b;
    logic neg_q;
    logic neg_r;

    always_comb begin
        neg_a   = signed_div_i & opdata1_i[REG_BUS-1];
        neg_b   = signed_div_i & opdata2_i[REG_BUS-1];
        mag_a   = neg_a ? neg_word(opdata1_i) : opdata1_i;
        mag_b   = neg_b ? neg_word(opdata2_i) : opdata2_i;
        quo_fix = neg_q ? neg_word(dvd) : dvd;
        rem_fix = neg_r ? neg_word(rem) : rem;
    end

    // Sign flags are captured alongside the operands so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_FREE && start_i == DIV_START && !annul_i) begin
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
        end
    end
`else
    logic unused_signed;

    always_comb begin
        unused_signed = signed_div_i;
        mag_a         = opdata1_i;
        mag_b         = opdata2_i;
        quo_fix       = dvd;
        rem_fix       = rem;
    end
`endif

    // The dividend register shifts out dividend bits at the top and collects quotient bits at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            divisor_r <= '0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == ZERO_WORD) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state     <= DIV_ON;
                            cnt       <= '0;
                            rem       <= '0;
                            dvd       <= mag_a;
                            divisor_r <= mag_b;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state    <= DIV_END;
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                        cnt   <= '0;
                    end else if (cnt != 6'd32) begin
                        rem <= step_rem;
                        dvd <= {dvd[REG_BUS-2:0], step_q};
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
